// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed hex seven-segment scanner with a double-buffered value and frame-aligned commit.
// Optional blink blanking is compiled in with `define SEVENSEG_BLINK_EN.
`timescale 1ns/1ps
module sevenseg_scan_driver #(
  parameter int NDIGITS      = 8,
  parameter int CLKDIV       = 50000,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int BLINK_FRAMES = 64,
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  output logic                   ready,
  input  logic                   lz_suppress,
  input  logic [NDIGITS-1:0]     blank_mask,
`ifdef SEVENSEG_BLINK_EN
  input  logic [NDIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     an,
  output logic [IW-1:0]          digit_idx,
  output logic                   frame_end
);

  localparam int               PW      = $clog2(CLKDIV);
  localparam logic [PW-1:0]    PLAST   = PW'(CLKDIV - 1);
  localparam logic [IW-1:0]    ILAST   = IW'(NDIGITS - 1);
  localparam logic [6:0]       SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [NDIGITS-1:0] AN_OFF = {NDIGITS{ACTIVE_LOW}};

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          cur_idx_q, cur_idx_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic [NDIGITS-1:0]     an_q, an_d;
  logic                   frame_end_q, frame_end_d;
  logic [4*NDIGITS-1:0]   disp_q, disp_d;
  logic [4*NDIGITS-1:0]   pend_q, pend_d;
  logic                   pend_full_q, pend_full_d;

  logic                   tick;
  logic                   frame_tick;
  logic                   blink_blank;
  logic                   digit_blank;
  logic [3:0]             cur_nib;
  logic [6:0]             seg_low;
  logic [NDIGITS-1:0]     an_low;
  logic [NDIGITS-1:0]     upper_zero;

  // Active-low pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // upper_zero[i]: nibbles i..NDIGITS-1 of the shown value are all zero.
  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_upper_zero
      assign upper_zero[gi] = (disp_q[4*NDIGITS-1:4*gi] == '0);
    end
  endgenerate

  assign tick       = (presc_q == PLAST);
  assign frame_tick = tick && (cur_idx_q == ILAST);
  assign cur_nib    = disp_q[{cur_idx_q, 2'b00} +: 4];

`ifdef SEVENSEG_BLINK_EN
  localparam int            BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bphase_q, bphase_d;

  always_comb begin
    bcnt_d   = bcnt_q;
    bphase_d = bphase_q;
    if (frame_tick) begin
      if (bcnt_q == BLAST) begin
        bcnt_d   = '0;
        bphase_d = ~bphase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q   <= '0;
      bphase_q <= 1'b0;
    end else begin
      bcnt_q   <= bcnt_d;
      bphase_q <= bphase_d;
    end
  end

  assign blink_blank = bphase_q & blink_mask[cur_idx_q];
`else
  assign blink_blank = 1'b0;
`endif

  // Blanked digits keep their enable so every slot has the same duty.
  assign digit_blank = blank_mask[cur_idx_q]
                     | (lz_suppress && (cur_idx_q != '0) && upper_zero[cur_idx_q])
                     | blink_blank;
  assign seg_low = digit_blank ? 7'b1111111 : hex_to_seg(cur_nib);
  assign an_low  = ~(NDIGITS'(1) << cur_idx_q);

  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    cur_idx_d   = cur_idx_q;
    idx_d       = idx_q;
    seg_d       = seg_q;
    an_d        = an_q;
    frame_end_d = 1'b0;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;

    if (tick) begin
      seg_d       = ACTIVE_LOW ? seg_low : ~seg_low;
      an_d        = ACTIVE_LOW ? an_low  : ~an_low;
      idx_d       = cur_idx_q;
      cur_idx_d   = (cur_idx_q == ILAST) ? '0 : cur_idx_q + 1'b1;
      frame_end_d = frame_tick;
    end

    // A load taken on the frame-end edge lands in pending (which was empty) and waits a frame.
    if (load && !pend_full_q) begin
      pend_d      = value;
      pend_full_d = 1'b1;
    end else if (frame_tick && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      cur_idx_q   <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      frame_end_q <= 1'b0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      cur_idx_q   <= cur_idx_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frame_end_q <= frame_end_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign ready     = ~pend_full_q;
  assign seg       = seg_q;
  assign an        = an_q;
  assign digit_idx = idx_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver (NDIGITS=4, CLKDIV=4, ACTIVE_LOW=1).
// Timing is tracked as posedge count since the last reset release; ticks land on every 4th edge.
`timescale 1ns/1ps
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        ready;
  logic        lz_suppress = 1'b0;
  logic [3:0]  blank_mask = '0;
`ifdef SEVENSEG_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_end;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt;

  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S_0 = 7'b1000000, S_1 = 7'b1111001, S_2 = 7'b0100100;
  localparam logic [6:0] S_3 = 7'b0110000, S_4 = 7'b0011001, S_5 = 7'b0010010;
  localparam logic [6:0] S_A = 7'b0001000, S_B = 7'b0000011, S_C = 7'b1000110;
  localparam logic [6:0] S_D = 7'b0100001, S_F = 7'b0001110;

  sevenseg_scan_driver #(
    .NDIGITS(4), .CLKDIV(4), .ACTIVE_LOW(1'b1), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .ready(ready),
    .lz_suppress(lz_suppress), .blank_mask(blank_mask),
`ifdef SEVENSEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg), .an(an), .digit_idx(digit_idx), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end else begin
      $display("ok   %s: %0h (edge %0d)", tag, got, edge_cnt);
    end
  endtask

  task automatic to_edge(input int t);
    while (edge_cnt < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_slot(input string tag, input int e, input logic [3:0] exp_an,
                            input logic [6:0] exp_seg, input int exp_idx);
    to_edge(e);
    check({tag, ".an"},  32'(an),  32'(exp_an));
    check({tag, ".seg"}, 32'(seg), 32'(exp_seg));
    check({tag, ".idx"}, 32'(digit_idx), 32'(exp_idx));
  endtask

  initial begin
    #30000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // 1: async reset mid-scan with pending full
    repeat (2) @(negedge clk);
    reset = 1'b0;
    to_edge(1); value = 16'h5555; load = 1'b1;
    to_edge(2); load = 1'b0;
    check("pre_rst.ready", 32'(ready), 32'd0);
    to_edge(6);
    check("pre_rst.an", 32'(an), 32'(4'b1110));
    #2 reset = 1'b1;
    #1;
    check("rst.an", 32'(an), 32'(4'b1111));
    check("rst.seg", 32'(seg), 32'(S_OFF));
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.idx", 32'(digit_idx), 32'd0);
    check("rst.frame_end", 32'(frame_end), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 2: load 0x1234, lz off
    to_edge(1); value = 16'h1234; load = 1'b1;
    to_edge(2); load = 1'b0;
    check("t2.ready_low", 32'(ready), 32'd0);
    to_edge(3);
    check("t2.no_tick_yet.an", 32'(an), 32'(4'b1111));
    check_slot("t2.first", 4, 4'b1110, S_0, 0);
    to_edge(15);
    check("t2.ready_still_low", 32'(ready), 32'd0);
    check("t2.fe_before", 32'(frame_end), 32'd0);
    check_slot("t2.old_d3", 16, 4'b0111, S_0, 3);
    check("t2.ready_back", 32'(ready), 32'd1);
    check("t2.fe_pulse", 32'(frame_end), 32'd1);
    to_edge(17);
    check("t2.fe_clear", 32'(frame_end), 32'd0);
    check_slot("t2.d0", 20, 4'b1110, S_4, 0);
    to_edge(23);
    check("t2.d0_hold.seg", 32'(seg), 32'(S_4));
    check_slot("t2.d1", 24, 4'b1101, S_3, 1);
    check_slot("t2.d2", 28, 4'b1011, S_2, 2);
    check_slot("t2.d3", 32, 4'b0111, S_1, 3);

    // 3: leading-zero suppression
    to_edge(33); lz_suppress = 1'b1; value = 16'h0050; load = 1'b1;
    to_edge(34); load = 1'b0;
    check_slot("t3.d0", 52, 4'b1110, S_0, 0);
    check_slot("t3.d1", 56, 4'b1101, S_5, 1);
    check_slot("t3.d2", 60, 4'b1011, S_OFF, 2);
    check_slot("t3.d3", 64, 4'b0111, S_OFF, 3);
    to_edge(65); value = 16'h0000; load = 1'b1;
    to_edge(66); load = 1'b0;
    check_slot("t3z.d0", 84, 4'b1110, S_0, 0);
    check_slot("t3z.d1", 88, 4'b1101, S_OFF, 1);
    check_slot("t3z.d2", 92, 4'b1011, S_OFF, 2);

    // 4: load on the frame-end tick edge, then an ignored load
    to_edge(95); value = 16'hABCD; load = 1'b1;
    check_slot("t4.d3", 96, 4'b0111, S_OFF, 3);
    load = 1'b0;
    check("t4.ready_low", 32'(ready), 32'd0);
    check_slot("t4.unchanged.d0", 100, 4'b1110, S_0, 0);
    to_edge(101); value = 16'h9999; load = 1'b1;
    to_edge(102); load = 1'b0;
    to_edge(111);
    check("t4.ready_low_16", 32'(ready), 32'd0);
    to_edge(112);
    check("t4.ready_high", 32'(ready), 32'd1);
    check_slot("t4.d0", 116, 4'b1110, S_D, 0);
    check_slot("t4.d1", 120, 4'b1101, S_C, 1);
    check_slot("t4.d2", 124, 4'b1011, S_B, 2);
    check_slot("t4.d3", 128, 4'b0111, S_A, 3);

    // 5: per-digit blank mask
    to_edge(129); lz_suppress = 1'b0; blank_mask = 4'b0010; value = 16'hFFFF; load = 1'b1;
    to_edge(130); load = 1'b0;
    check("t5.ready_low", 32'(ready), 32'd0);
    check_slot("t5.d0", 148, 4'b1110, S_F, 0);
    check_slot("t5.d1", 152, 4'b1101, S_OFF, 1);
    check_slot("t5.d2", 156, 4'b1011, S_F, 2);
    check_slot("t5.d3", 160, 4'b0111, S_F, 3);
    pulses = 0;
    for (int i = 161; i <= 176; i++) begin
      to_edge(i);
      if (frame_end) pulses++;
    end
    check("t5.fe_per_frame", 32'(pulses), 32'd1);

`ifdef SEVENSEG_BLINK_EN
    // 6: blink digit 0, two frames per half-period
    to_edge(177); blink_mask = 4'b0001;
    check_slot("t6.blank_a", 180, 4'b1110, S_OFF, 0);
    check_slot("t6.vis_a", 196, 4'b1110, S_F, 0);
    check_slot("t6.vis_b", 212, 4'b1110, S_F, 0);
    check_slot("t6.blank_b", 228, 4'b1110, S_OFF, 0);
    check_slot("t6.blank_c", 244, 4'b1110, S_OFF, 0);
    check_slot("t6.vis_c", 260, 4'b1110, S_F, 0);
    check_slot("t6.d2", 268, 4'b1011, S_F, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Parametrised, time-multiplexed hex seven-segment display driver for on-board debug output. It accepts an NDIGITS-nibble value through a load/ready handshake and double-buffers it, committing new values only at scan-frame boundaries so the display never tears. It scans one digit at a time through a shared segment bus and a one-hot digit enable, with optional leading-zero suppression and per-digit blanking. It sits between the debug value tap and the board's display pins.

Parameters:
NDIGITS, 8, number of hex digits scanned (1..16).
CLKDIV, 50000, clk cycles per digit slot (>=2).
ACTIVE_LOW, 1, 1 = segments and enables are low-true (board default); 0 = high-true.
BLINK_FRAMES, 64, full scan frames per blink half-period (used only with SEVENSEG_BLINK_EN).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
value  in  4*NDIGITS  hex value; nibble i drives digit i (digit 0 = bits [3:0])
load  in  1  request to capture value
ready  out  1  pending buffer empty; load accepted when load && ready
lz_suppress  in  1  1 = blank leading zero digits
blank_mask  in  NDIGITS  bit i = 1 forces digit i blank
seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}
an  out  NDIGITS  one-hot digit enable
digit_idx  out  $clog2(NDIGITS) (min 1)  index of digit currently driven
frame_end  out  1  one-cycle pulse on the last digit slot of each frame

Behaviour:
- Reset (async, active-high, effective without a clock edge): prescaler=0, digit_idx=0, display register=0, pending empty, ready=1, frame_end=0, an=all off, seg=all off. With ACTIVE_LOW=1, "off" is all ones.
- Prescaler: counts 0..CLKDIV-1. tick = (count==CLKDIV-1), then wraps to 0.
- On each tick edge: seg/an register the decode of digit cur_idx; digit_idx then takes cur_idx, and cur_idx advances (wraps NDIGITS-1 -> 0). The first tick after reset shows digit 0. Outputs are registered and glitch-free; seg and an change on the same edge.
- frame_end: 1 for the cycle following the tick that loads digit NDIGITS-1.
- Handshake:
  - load && ready on an edge copies value into pending; ready=0 from the next cycle.
  - On the frame-end tick edge, if pending is full it is copied to the display register, and ready=1 from the next cycle.
  - Load is ignored while ready=0; no overwrite occurs.
  - A load accepted on the frame-end tick edge itself goes to pending and commits only at the following frame end.
- Decode, active-low, indexed by nibble 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110. ACTIVE_LOW=0 inverts both seg and an.
- Blanking: digit i outputs seg=off while its an bit stays asserted, which keeps duty uniform. A digit is blanked when blank_mask[i]=1, or when lz_suppress=1, i>0, and display nibbles i..NDIGITS-1 are all zero. Digit 0 is never zero-suppressed. lz_suppress and blank_mask are sampled at each tick.

Optional Feature:
SEVENSEG_BLINK_EN.
- Defined:
  - Adds input blink_mask [NDIGITS-1:0] and a frame counter 0..BLINK_FRAMES-1 that toggles blink_phase on wrap.
  - While blink_phase=1, digits with blink_mask[i]=1 are blanked.
  - Reset clears the counter and sets blink_phase=0.
- Undefined: no port, no counter, no blink blanking.

Test Plan:
Bench uses NDIGITS=4, CLKDIV=4, ACTIVE_LOW=1.
1. Assert reset asynchronously mid-scan -> same cycle an=1111, seg=1111111, ready=1, digit_idx=0; after release, first tick at cycle 4.
2. Load 0x1234, lz=0 -> ready=0 next cycle, commits at frame end; next frame shows: an=1110 seg=0011001; 1101/0110000; 1011/0100100; 0111/1111001; each slot 4 cycles; frame_end pulses once per 16 cycles.
3. lz=1, load 0x0050 -> digits 3,2 seg=1111111, digit1=0010010, digit0=1000000. Then load 0x0000 -> only digit0 shows 1000000.
4. Load asserted on the frame-end tick edge with pending empty -> display unchanged that frame, ready low 16 cycles, commit at next frame end. A second load while ready=0 is ignored.
5. blank_mask=0010 with value 0xFFFF -> digit1 seg=1111111, others 0001110, an still cycles.
6. With SEVENSEG_BLINK_EN and BLINK_FRAMES=2, blink_mask=0001 -> digit0 visible 2 frames, blank 2 frames, repeating.
